// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory request sequencer: FSM encoding,
// legal core-count range and command-vector encodings.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NOC_MIN = 1;
    localparam int NOC_MAX = 4;

    localparam logic [1:0] CMD_NONE     = 2'b00;
    localparam logic [1:0] CMD_SHARED   = 2'b01;
    localparam logic [1:0] CMD_DISTINCT = 2'b11;

endpackage

// File: rtl/mem_seq_beat_counter.sv
// Loadable down-counter; last is high when the count has reached zero,
// so loading N-1 gives exactly N cycles before last.
module mem_seq_beat_counter #(
    parameter int CW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          last
);

    logic [CW-1:0] count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/mem_request_sequencer.sv
// Turns one start pulse into a registered read/write command burst for the
// memory control unit, waits out read latency, then pulses done.
module mem_request_sequencer
    import mem_seq_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int RD_LAT = 2,
    parameter int NOC_W  = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_wr,
    input  logic             i_distinct,
    input  logic [NOC_W-1:0] i_noc,
    input  logic [AW-1:0]    i_ar1,
    input  logic [AW-1:0]    i_ar2,
    input  logic [AW-1:0]    i_ar3,
    input  logic [AW-1:0]    i_ar4,
    input  logic [DW-1:0]    i_dr1,
    input  logic [DW-1:0]    i_dr2,
    input  logic [DW-1:0]    i_dr3,
    input  logic [DW-1:0]    i_dr4,
    output logic [1:0]       o_read,
    output logic [1:0]       o_write,
    output logic [AW-1:0]    o_ar1,
    output logic [AW-1:0]    o_ar2,
    output logic [AW-1:0]    o_ar3,
    output logic [AW-1:0]    o_ar4,
    output logic [DW-1:0]    o_dr1,
    output logic [DW-1:0]    o_dr2,
    output logic [DW-1:0]    o_dr3,
    output logic [DW-1:0]    o_dr4,
    output logic [NOC_W-1:0] o_noc,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int CNT_MAX = (RD_LAT > NOC_MAX) ? RD_LAT : NOC_MAX;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        state, next_state;
    logic          wr_q, distinct_q;
    logic          accept, noc_legal, err_n;
    logic          cnt_load, cnt_dec, cnt_last;
    logic [CW-1:0] cnt_load_val;
    logic          wr_sel, dist_sel;
    logic [1:0]    cmd_n;

    assign noc_legal = (i_noc >= NOC_W'(NOC_MIN)) && (i_noc <= NOC_W'(NOC_MAX));

    mem_seq_beat_counter #(.CW(CW)) u_beat_counter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    // The counter is reused: beats-1 on acceptance, RD_LAT-1 on entry to DRAIN.
    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        err_n        = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (noc_legal) begin
                        accept       = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = i_distinct ? (CW'(i_noc) - CW'(1)) : '0;
                        next_state   = ISSUE;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (cnt_last) begin
                    if (wr_q || (RD_LAT == 0)) begin
                        next_state = DONE;
                    end else begin
                        cnt_load     = 1'b1;
                        cnt_load_val = CW'(RD_LAT - 1);
                        next_state   = DRAIN;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_last) begin
                    next_state = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // On the accepting edge the latched copies are not yet valid, so
    // the first command beat is built from the live inputs.
    assign wr_sel   = accept ? i_wr       : wr_q;
    assign dist_sel = accept ? i_distinct : distinct_q;
    assign cmd_n    = dist_sel ? CMD_DISTINCT : CMD_SHARED;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // All outputs are registered from next-state decode so the control
    // unit sees glitch-free levels aligned with the FSM state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_read     <= CMD_NONE;
            o_write    <= CMD_NONE;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            wr_q       <= 1'b0;
            distinct_q <= 1'b0;
            o_noc      <= '0;
            o_ar1      <= '0;
            o_ar2      <= '0;
            o_ar3      <= '0;
            o_ar4      <= '0;
            o_dr1      <= '0;
            o_dr2      <= '0;
            o_dr3      <= '0;
            o_dr4      <= '0;
        end else begin
            o_read  <= ((next_state == ISSUE) && !wr_sel) ? cmd_n : CMD_NONE;
            o_write <= ((next_state == ISSUE) &&  wr_sel) ? cmd_n : CMD_NONE;
            o_busy  <= (next_state != IDLE);
            o_done  <= (next_state == DONE);
            o_err   <= err_n;
            if (accept) begin
                wr_q       <= i_wr;
                distinct_q <= i_distinct;
                o_noc      <= i_noc;
                o_ar1      <= i_ar1;
                o_ar2      <= i_ar2;
                o_ar3      <= i_ar3;
                o_ar4      <= i_ar4;
                o_dr1      <= i_dr1;
                o_dr2      <= i_dr2;
                o_dr3      <= i_dr3;
                o_dr4      <= i_dr4;
            end
        end
    end

endmodule
